// File: rtl/cbfp_block_norm_if.sv
// Streaming sample bus for the CBFP normaliser: input beats in, normalised beats out.
interface cbfp_block_norm_if #(
  parameter int unsigned LANES = 16,
  parameter int unsigned IN_W  = 25,
  parameter int unsigned OUT_W = 12,
  parameter int unsigned IDX_W = 5
);
  logic                    din_valid;
  logic signed [IN_W-1:0]  din_i [LANES];
  logic signed [IN_W-1:0]  din_q [LANES];
  logic                    mode_sep;
  logic                    dout_valid;
  logic                    dout_first;
  logic                    dout_last;
  logic signed [OUT_W-1:0] dout_i [LANES];
  logic signed [OUT_W-1:0] dout_q [LANES];
  logic [IDX_W-1:0]        idx_re;
  logic [IDX_W-1:0]        idx_im;

  modport slave (
    input  din_valid, din_i, din_q, mode_sep,
    output dout_valid, dout_first, dout_last, dout_i, dout_q, idx_re, idx_im
  );

  modport master (
    output din_valid, din_i, din_q, mode_sep,
    input  dout_valid, dout_first, dout_last, dout_i, dout_q, idx_re, idx_im
  );
endinterface

// File: rtl/cbfp_block_norm.sv
// Convergent block-floating-point normaliser with a two-bank ping-pong block buffer.
module cbfp_block_norm #(
  parameter int unsigned LANES = 16,
  parameter int unsigned IN_W  = 25,
  parameter int unsigned OUT_W = 12,
  parameter int unsigned BEATS = 4,
  parameter int unsigned IDX_W = 5
) (
  input logic             clk,
  input logic             rstn,
  cbfp_block_norm_if.slave bus
);
  localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LastBeat = CW'(BEATS - 1);
  localparam logic [IDX_W-1:0] MaxIdx = IDX_W'(IN_W - 1);
  localparam logic signed [IN_W:0] Rnd = (IN_W + 1)'(2 ** (IN_W - OUT_W - 1));

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  // Redundant sign bits: leading bits equal to the MSB, minus one.
  function automatic logic [IDX_W-1:0] rsb(input logic [IN_W-1:0] x);
    logic [IDX_W-1:0] r;
    logic run;
    r = '0;
    run = 1'b1;
    for (int i = IN_W - 2; i >= 0; i--) begin
      if (run && (x[i] == x[IN_W-1])) r = r + 1'b1;
      else run = 1'b0;
    end
    return r;
  endfunction

  // Shift, round half up, keep the top OUT_W+1 bits, then saturate to OUT_W.
  function automatic logic signed [OUT_W-1:0] norm(input logic signed [IN_W-1:0] x,
                                                   input logic [IDX_W-1:0] s);
    logic signed [IN_W:0] sum;
    logic signed [OUT_W:0] t;
    sum = ($signed({x[IN_W-1], x}) <<< s) + Rnd;
    t = sum[IN_W -: OUT_W + 1];
    if (t[OUT_W] != t[OUT_W-1]) begin
      return t[OUT_W] ? {1'b1, {(OUT_W - 1){1'b0}}} : {1'b0, {(OUT_W - 1){1'b1}}};
    end
    return t[OUT_W-1:0];
  endfunction

  logic signed [IN_W-1:0] mem_i_q [2][BEATS][LANES];
  logic signed [IN_W-1:0] mem_q_q [2][BEATS][LANES];

  logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] m_re_q, m_re_d, m_im_q, m_im_d;
  logic             mode_q, mode_d;
  logic [IDX_W-1:0] s_re_q [2], s_re_d [2], s_im_q [2], s_im_d [2];
  logic [1:0]       full_q, full_d, full_set, full_clr;

  state_e           state_q, state_d;
  logic             rd_bank_q, rd_bank_d;
  logic [CW-1:0]    rd_cnt_q, rd_cnt_d;

  logic                    dv_q, dv_d, first_q, first_d, last_q, last_d;
  logic signed [OUT_W-1:0] dout_i_q [LANES], dout_i_d [LANES];
  logic signed [OUT_W-1:0] dout_q_q [LANES], dout_q_d [LANES];
  logic [IDX_W-1:0]        idx_re_q, idx_re_d, idx_im_q, idx_im_d;

  logic [IDX_W-1:0] beat_re, beat_im, m_re_cur, m_im_cur, m_both;
  logic             mode_cur;

  // Per-beat minimum redundant-sign count, merged into the block's running minima.
  always_comb begin
    beat_re = MaxIdx;
    beat_im = MaxIdx;
    for (int l = 0; l < LANES; l++) begin
      if (rsb(bus.din_i[l]) < beat_re) beat_re = rsb(bus.din_i[l]);
      if (rsb(bus.din_q[l]) < beat_im) beat_im = rsb(bus.din_q[l]);
    end
    m_re_cur = (beat_re < m_re_q) ? beat_re : m_re_q;
    m_im_cur = (beat_im < m_im_q) ? beat_im : m_im_q;
    m_both   = (m_re_cur < m_im_cur) ? m_re_cur : m_im_cur;
    mode_cur = (wr_cnt_q == '0) ? bus.mode_sep : mode_q;
  end

  // Write side: beat counter, minima tracking and block close.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    m_re_d    = m_re_q;
    m_im_d    = m_im_q;
    mode_d    = mode_q;
    s_re_d    = s_re_q;
    s_im_d    = s_im_q;
    full_set  = '0;
    if (bus.din_valid) begin
      mode_d = mode_cur;
      if (wr_cnt_q == LastBeat) begin
        wr_cnt_d  = '0;
        wr_bank_d = ~wr_bank_q;
        m_re_d    = MaxIdx;
        m_im_d    = MaxIdx;
        s_re_d[wr_bank_q]   = mode_cur ? m_re_cur : m_both;
        s_im_d[wr_bank_q]   = mode_cur ? m_im_cur : m_both;
        full_set[wr_bank_q] = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
        m_re_d   = m_re_cur;
        m_im_d   = m_im_cur;
      end
    end
  end

  // Read side FSM and registered output beat.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_cnt_d  = rd_cnt_q;
    full_clr  = '0;
    dv_d      = 1'b0;
    first_d   = 1'b0;
    last_d    = 1'b0;
    dout_i_d  = dout_i_q;
    dout_q_d  = dout_q_q;
    idx_re_d  = idx_re_q;
    idx_im_d  = idx_im_q;
    unique case (state_q)
      StIdle: begin
        if (full_q[rd_bank_q]) begin
          state_d  = StRead;
          rd_cnt_d = '0;
        end
      end
      StRead: begin
        dv_d     = 1'b1;
        first_d  = (rd_cnt_q == '0);
        last_d   = (rd_cnt_q == LastBeat);
        idx_re_d = s_re_q[rd_bank_q];
        idx_im_d = s_im_q[rd_bank_q];
        for (int l = 0; l < LANES; l++) begin
          dout_i_d[l] = norm(mem_i_q[rd_bank_q][rd_cnt_q][l], s_re_q[rd_bank_q]);
          dout_q_d[l] = norm(mem_q_q[rd_bank_q][rd_cnt_q][l], s_im_q[rd_bank_q]);
        end
        if (rd_cnt_q == LastBeat) begin
          full_clr[rd_bank_q] = 1'b1;
          rd_bank_d = ~rd_bank_q;
          rd_cnt_d  = '0;
          // A block closing on this very edge still counts, so the stream stays gapless.
          if (!(full_q[~rd_bank_q] || full_set[~rd_bank_q])) state_d = StIdle;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    full_d = (full_q & ~full_clr) | full_set;
  end

  // Sample storage; contents are qualified by the full flags, so no reset needed.
  always_ff @(posedge clk) begin
    if (bus.din_valid) begin
      for (int l = 0; l < LANES; l++) begin
        mem_i_q[wr_bank_q][wr_cnt_q][l] <= bus.din_i[l];
        mem_q_q[wr_bank_q][wr_cnt_q][l] <= bus.din_q[l];
      end
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      m_re_q    <= MaxIdx;
      m_im_q    <= MaxIdx;
      mode_q    <= 1'b0;
      s_re_q    <= '{default: '0};
      s_im_q    <= '{default: '0};
      full_q    <= '0;
      state_q   <= StIdle;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
      dv_q      <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      dout_i_q  <= '{default: '0};
      dout_q_q  <= '{default: '0};
      idx_re_q  <= '0;
      idx_im_q  <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      m_re_q    <= m_re_d;
      m_im_q    <= m_im_d;
      mode_q    <= mode_d;
      s_re_q    <= s_re_d;
      s_im_q    <= s_im_d;
      full_q    <= full_d;
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
      dv_q      <= dv_d;
      first_q   <= first_d;
      last_q    <= last_d;
      dout_i_q  <= dout_i_d;
      dout_q_q  <= dout_q_d;
      idx_re_q  <= idx_re_d;
      idx_im_q  <= idx_im_d;
    end
  end

  assign bus.dout_valid = dv_q;
  assign bus.dout_first = first_q;
  assign bus.dout_last  = last_q;
  assign bus.dout_i     = dout_i_q;
  assign bus.dout_q     = dout_q_q;
  assign bus.idx_re     = idx_re_q;
  assign bus.idx_im     = idx_im_q;
endmodule

// File: tb/tb_cbfp_block_norm.sv
// Directed bench for cbfp_block_norm with hand-computed expectations.
module tb_cbfp_block_norm;
  localparam int unsigned LANES = 16;
  localparam int unsigned IN_W  = 25;
  localparam int unsigned OUT_W = 12;
  localparam int unsigned BEATS = 4;
  localparam int unsigned IDX_W = 5;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cbfp_block_norm_if #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) bus ();

  cbfp_block_norm #(
    .LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .BEATS(BEATS), .IDX_W(IDX_W)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct {
    int cyc;
    int first;
    int last;
    int ire;
    int iim;
    int i0;
    int i1;
    int q0;
  } beat_t;

  beat_t obs_q[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Record every output beat with the index of the edge that registered it.
  initial forever begin
    beat_t b;
    @(negedge clk);
    if (bus.dout_valid) begin
      b.cyc   = cyc;
      b.first = int'(bus.dout_first);
      b.last  = int'(bus.dout_last);
      b.ire   = int'(bus.idx_re);
      b.iim   = int'(bus.idx_im);
      b.i0    = int'(bus.dout_i[0]);
      b.i1    = int'(bus.dout_i[1]);
      b.q0    = int'(bus.dout_q[0]);
      obs_q.push_back(b);
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_beat(input int i0, input int irest, input int qv, input bit m);
    @(negedge clk);
    bus.din_valid = 1'b1;
    bus.mode_sep  = m;
    for (int l = 0; l < LANES; l++) begin
      bus.din_i[l] = (l == 0) ? IN_W'(i0) : IN_W'(irest);
      bus.din_q[l] = IN_W'(qv);
    end
  endtask

  task automatic idle_beat();
    @(negedge clk);
    bus.din_valid = 1'b0;
  endtask

  // Beat 0 carries i0f in lane 0; returns the edge at which beat 0 is accepted.
  task automatic send_block(input int i0f, input int irest, input int qv, input bit m,
                            output int t0);
    t0 = 0;
    for (int b = 0; b < BEATS; b++) begin
      drive_beat((b == 0) ? i0f : irest, irest, qv, m);
      if (b == 0) t0 = cyc + 1;
    end
  endtask

  task automatic check_block(input string tag, input int k, input int t_exp, input int ire,
                             input int iim, input int i0f, input int i0, input int i1,
                             input int q0);
    for (int j = 0; j < BEATS; j++) begin
      if (k + j < obs_q.size()) begin
        check_eq($sformatf("%s.b%0d.cyc", tag, j), obs_q[k+j].cyc, t_exp + j);
        check_eq($sformatf("%s.b%0d.first", tag, j), obs_q[k+j].first, int'(j == 0));
        check_eq($sformatf("%s.b%0d.last", tag, j), obs_q[k+j].last, int'(j == BEATS - 1));
        check_eq($sformatf("%s.b%0d.idx_re", tag, j), obs_q[k+j].ire, ire);
        check_eq($sformatf("%s.b%0d.idx_im", tag, j), obs_q[k+j].iim, iim);
        check_eq($sformatf("%s.b%0d.i0", tag, j), obs_q[k+j].i0, (j == 0) ? i0f : i0);
        check_eq($sformatf("%s.b%0d.i1", tag, j), obs_q[k+j].i1, i1);
        check_eq($sformatf("%s.b%0d.q0", tag, j), obs_q[k+j].q0, q0);
      end
    end
  endtask

  initial begin
    int t;
    bus.din_valid = 1'b0;
    bus.mode_sep  = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      bus.din_i[l] = '0;
      bus.din_q[l] = '0;
    end

    // Reset held with input activity: outputs stay quiet.
    for (int c = 0; c < 6; c++) begin
      drive_beat(1000, 1000, 1000, 1'b0);
      bus.din_valid = c[0];
      check_eq("rst.dout_valid", int'(bus.dout_valid), 0);
      check_eq("rst.dout_i0", int'(bus.dout_i[0]), 0);
      check_eq("rst.idx_re", int'(bus.idx_re), 0);
    end
    @(negedge clk);
    bus.din_valid = 1'b0;
    rstn = 1'b1;
    repeat (8) @(posedge clk);
    check_eq("rst.no_output", obs_q.size(), 0);
    obs_q.delete();

    // Shared exponent.
    send_block(1000, 1000, 0, 1'b0, t);
    idle_beat();
    repeat (12) @(posedge clk);
    check_eq("shared.n", obs_q.size(), BEATS);
    check_block("shared", 0, t + BEATS + 1, 14, 14, 2000, 2000, 2000, 0);
    obs_q.delete();

    // Separate exponents.
    send_block(1000, 1000, 0, 1'b1, t);
    idle_beat();
    repeat (12) @(posedge clk);
    check_eq("sep.n", obs_q.size(), BEATS);
    check_block("sep", 0, t + BEATS + 1, 14, 24, 2000, 2000, 2000, 0);
    obs_q.delete();

    // Positive saturation with round-half-up on the remaining samples.
    send_block(2 ** 24 - 1, 8192, 8192, 1'b0, t);
    idle_beat();
    repeat (12) @(posedge clk);
    check_eq("sat.n", obs_q.size(), BEATS);
    check_block("sat", 0, t + BEATS + 1, 0, 0, 2047, 1, 1, 1);
    obs_q.delete();

    // All -1: maximal shift lands exactly on the negative rail.
    send_block(-1, -1, -1, 1'b0, t);
    idle_beat();
    repeat (12) @(posedge clk);
    check_eq("neg.n", obs_q.size(), BEATS);
    check_block("neg", 0, t + BEATS + 1, 24, 24, -2048, -2048, -2048, -2048);
    obs_q.delete();

    // Three gapless blocks, each with its own exponent.
    begin
      int t1, t2;
      send_block(1000, 1000, 0, 1'b0, t);
      send_block(100, 100, 0, 1'b0, t1);
      send_block(-3000, -3000, 0, 1'b0, t2);
    end
    idle_beat();
    repeat (20) @(posedge clk);
    check_eq("stream.n", obs_q.size(), 3 * BEATS);
    check_block("stream0", 0, t + 5, 14, 14, 2000, 2000, 2000, 0);
    check_block("stream1", BEATS, t + 9, 17, 17, 1600, 1600, 1600, 0);
    check_block("stream2", 2 * BEATS, t + 13, 12, 12, -1500, -1500, -1500, 0);
    obs_q.delete();

    // Reset mid-block: the partial block (large samples, small index) must vanish.
    drive_beat(2 ** 20, 2 ** 20, 2 ** 20, 1'b0);
    drive_beat(2 ** 20, 2 ** 20, 2 ** 20, 1'b0);
    @(negedge clk);
    bus.din_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    send_block(1000, 1000, 0, 1'b0, t);
    idle_beat();
    repeat (16) @(posedge clk);
    check_eq("midrst.n", obs_q.size(), BEATS);
    check_block("midrst", 0, t + BEATS + 1, 14, 14, 2000, 2000, 2000, 0);
    obs_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
